// File: rtl/mc_controller.sv
// Multicycle controller: Moore FSM, ALU decoder, condition-flag register and write gating.
// Optional build macro MC_MEM_WAIT_EN: FETCH, MEMREAD and MEMWRITE stall until MemReady=1.
module mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] EXECI    = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;

  logic [3:0] state_reg, state_next;
  logic [3:0] flags_reg;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       mem_ok;
  logic       next_pc, ir_write, reg_w, mem_w, alu_op, branch;
  logic       is_add, is_sub;
  logic [1:0] flag_w;
  logic       cond_ex;
  logic       unused_instr;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign rd    = Instr[15:12];
  assign unused_instr = ^{Instr[19:16], Instr[11:0]};

`ifdef MC_MEM_WAIT_EN
  assign mem_ok = MemReady;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = MemReady;
  assign mem_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= FETCH;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:    if (mem_ok) state_next = DECODE;
      DECODE: begin
        case (op)
          2'b00:   state_next = funct[5] ? EXECI : EXECR;
          2'b01:   state_next = MEMADR;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR:   state_next = funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ok) state_next = MEMWB;
      MEMWRITE: if (mem_ok) state_next = FETCH;
      EXECR,
      EXECI:    state_next = ALUWB;
      MEMWB,
      ALUWB,
      BRANCH:   state_next = FETCH;
      default:  state_next = FETCH;
    endcase
  end

  // Raw Moore outputs; the memory handshakes are qualified by mem_ok.
  always_comb begin
    next_pc   = 1'b0;
    ir_write  = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    alu_op    = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state_reg)
      FETCH: begin
        ir_write  = mem_ok;
        next_pc   = mem_ok;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = mem_ok;
      end
      EXECR:    alu_op = 1'b1;
      EXECI: begin
        alu_op  = 1'b1;
        ALUSrcB = 2'b01;
      end
      ALUWB:    reg_w = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};

  always_comb begin
    ALUControl = 2'b00;
    if (alu_op) begin
      case (funct[4:1])
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        default: ALUControl = 2'b00;
      endcase
    end
  end

  assign is_add = (funct[4:1] == 4'b0100);
  assign is_sub = (funct[4:1] == 4'b0010);
  assign flag_w[1] = alu_op & funct[0];
  assign flag_w[0] = flag_w[1] & (is_add | is_sub);

  // flags_reg = {N,Z,C,V}; alu_op is high only in EXECR/EXECI, so the write lands on the edge leaving them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_reg <= 4'b0000;
    end else if (cond_ex) begin
      if (flag_w[1]) flags_reg[3:2] <= ALUFlags[3:2];
      if (flag_w[0]) flags_reg[1:0] <= ALUFlags[1:0];
    end
  end

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_reg;
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Enables are also gated by reset so they drop the instant reset asserts.
  assign RegWrite = reset & reg_w & cond_ex;
  assign MemWrite = reset & mem_w & cond_ex;
  assign IRWrite  = reset & ir_write;
  assign PCWrite  = reset & (next_pc | (branch & cond_ex) |
                             (reg_w & cond_ex & (rd == 4'b1111)));

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller; the state is inferred from the output signature each cycle.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;

  int checks = 0;
  int failures = 0;

  mc_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ResultSrc(ResultSrc), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
  );

  always #5 clk = ~clk;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ALUSrcA,ResultSrc,ALUSrcB,ALUControl}
  logic [11:0] ctl;
  assign ctl = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA,
                ResultSrc, ALUSrcB, ALUControl};

  localparam logic [11:0] C_FETCH = 12'b1_0_0_1_0_1_10_10_00;
  localparam logic [11:0] C_DEC   = 12'b0_0_0_0_0_1_10_10_00;
  localparam logic [11:0] C_RST   = 12'b0_0_0_0_0_1_10_10_00;
  localparam logic [11:0] C_AWB   = 12'b0_0_0_0_1_0_00_00_00;
  localparam logic [11:0] C_AWBN  = 12'b0_0_0_0_0_0_00_00_00;
  localparam logic [11:0] C_AWBPC = 12'b1_0_0_0_1_0_00_00_00;
  localparam logic [11:0] C_MADR  = 12'b0_0_0_0_0_0_00_01_00;
  localparam logic [11:0] C_MRD   = 12'b0_1_0_0_0_0_00_00_00;
  localparam logic [11:0] C_MWB   = 12'b0_0_0_0_1_0_01_00_00;
  localparam logic [11:0] C_MWR   = 12'b0_1_1_0_0_0_00_00_00;
  localparam logic [11:0] C_BRT   = 12'b1_0_0_0_0_0_10_01_00;
  localparam logic [11:0] C_BRN   = 12'b0_0_0_0_0_0_10_01_00;

  function automatic logic [11:0] c_exr(input logic [1:0] ac);
    return {10'b0_0_0_0_0_0_00_00, ac};
  endfunction

  function automatic logic [11:0] c_exi(input logic [1:0] ac);
    return {10'b0_0_0_0_0_0_00_01, ac};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic at(input string tag, input logic [11:0] exp);
    check(tag, {20'd0, ctl}, {20'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic run_dp(input string tag, input logic [31:0] ins, input logic [3:0] fl,
                        input logic [11:0] exec_exp, input logic [11:0] wb_exp);
    Instr    = ins;
    ALUFlags = fl;
    at({tag, "_fetch"}, C_FETCH);
    at({tag, "_decode"}, C_DEC);
    at({tag, "_exec"}, exec_exp);
    at({tag, "_aluwb"}, wb_exp);
  endtask

  task automatic run_br(input string tag, input logic [31:0] ins, input logic [11:0] br_exp);
    Instr = ins;
    at({tag, "_fetch"}, C_FETCH);
    at({tag, "_decode"}, C_DEC);
    at({tag, "_branch"}, br_exp);
  endtask

  initial begin
    reset    = 1'b0;
    Instr    = 32'hE0812003;
    ALUFlags = 4'b0000;
    MemReady = 1'b1;
    #12;
    check("reset_ctl", {20'd0, ctl}, {20'd0, C_RST});
    @(negedge clk);
    reset = 1'b1;
    #1;

    run_dp("add", 32'hE0812003, 4'b0000, c_exr(2'b00), C_AWB);

    run_dp("subs_z", 32'hE0512003, 4'b0100, c_exr(2'b01), C_AWB);
    run_br("bne_nt", 32'h1A000002, C_BRN);
    run_dp("subs_nz", 32'hE0512003, 4'b0000, c_exr(2'b01), C_AWB);
    run_br("bne_t", 32'h1A000002, C_BRT);
    check("br_srcs", {28'd0, RegSrc, ImmSrc}, {28'd0, 4'b0110});

    run_dp("and", 32'hE0012003, 4'b0000, c_exr(2'b10), C_AWB);
    run_dp("orr", 32'hE1812003, 4'b0000, c_exr(2'b11), C_AWB);
    run_dp("eor", 32'hE0212003, 4'b0000, c_exr(2'b00), C_AWB);

    // ANDS clears N,Z but must leave C,V as set by the SUBS.
    run_dp("subs_all", 32'hE0512003, 4'b1111, c_exr(2'b01), C_AWB);
    run_dp("ands", 32'hE0112003, 4'b0000, c_exr(2'b10), C_AWB);
    run_dp("add_nos", 32'hE0812003, 4'b0100, c_exr(2'b00), C_AWB);
    run_br("bcs_t", 32'h2A000002, C_BRT);
    run_br("beq_nt", 32'h0A000002, C_BRN);

    run_dp("cond_nv", 32'hF0812003, 4'b0000, c_exr(2'b00), C_AWBN);
    run_dp("add_pc", 32'hE281F004, 4'b0000, c_exi(2'b00), C_AWBPC);

    Instr = 32'hE5912000;
    at("ldr_fetch", C_FETCH);
    check("ldr_srcs", {28'd0, RegSrc, ImmSrc}, {28'd0, 4'b1001});
    at("ldr_decode", C_DEC);
    at("ldr_memadr", C_MADR);
    at("ldr_memread", C_MRD);
    at("ldr_memwb", C_MWB);

    Instr = 32'hE5812000;
    at("str_fetch", C_FETCH);
    at("str_decode", C_DEC);
    at("str_memadr", C_MADR);
    at("str_memwrite", C_MWR);

    Instr = 32'hEC000000;
    at("op11_fetch", C_FETCH);
    at("op11_decode", C_DEC);

    Instr = 32'hE0812003;
`ifdef MC_MEM_WAIT_EN
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) at("wait_fetch", C_RST);
    MemReady = 1'b1;
    at("wait_fetch_rdy", C_FETCH);
`else
    MemReady = 1'b0;
    at("nowait_fetch", C_FETCH);
`endif
    at("wait_decode", C_DEC);
    MemReady = 1'b1;
    at("wait_exec", c_exr(2'b00));
    at("wait_aluwb", C_AWB);

    Instr = 32'hE5912000;
    at("rst_ldr_fetch", C_FETCH);
    at("rst_ldr_decode", C_DEC);
    at("rst_ldr_memadr", C_MADR);
    at("rst_ldr_memread", C_MRD);
    check("rst_ldr_memwb", {20'd0, ctl}, {20'd0, C_MWB});
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_ctl", {20'd0, ctl}, {20'd0, C_RST});
    check("rst_async_regwrite", {31'd0, RegWrite}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    run_br("bcs_after_rst", 32'h2A000002, C_BRN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- Instr  in  32  latched instruction: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12].
- ALUFlags  in  4  {N,Z,C,V} from the ALU.
- MemReady  in  1  memory access complete.
- PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA  out  1 each  datapath enables and selects.
- ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl  out  2 each  datapath selects.
REQ-002 The block SHALL have no parameters; the state encoding is internal.

Function
REQ-003 The block SHALL implement a Moore FSM with these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
REQ-004 The FSM SHALL use these transitions:
- FETCH->DECODE.
- From DECODE, by Op: 00 goes to EXECI if Funct[5]=1, otherwise EXECR; 01 goes to MEMADR; 10 goes to BRANCH; 11 goes to FETCH.
- MEMADR goes to MEMREAD if Funct[0]=1, otherwise MEMWRITE.
- MEMREAD->MEMWB; EXECR and EXECI->ALUWB.
- MEMWB, MEMWRITE, ALUWB and BRANCH->FETCH.
REQ-005 The raw state outputs SHALL be as follows; any signal not listed is 0:
- FETCH: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWRITE: AdrSrc=1, MemW=1.
- EXECR: ALUOp=1, ALUSrcB=00.
- EXECI: ALUOp=1, ALUSrcB=01.
- ALUWB: RegW=1.
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-006 The remaining outputs SHALL be decoded combinationally from Op: ImmSrc=Op, RegSrc[0]=(Op==10), RegSrc[1]=(Op==01).
REQ-007 When ALUOp=1, ALUControl SHALL be decoded from Funct[4:1]: 0100 gives 00 (ADD), 0010 gives 01 (SUB), 0000 gives 10 (AND), 1100 gives 11 (ORR), and any other code gives 00; when ALUOp=0, ALUControl SHALL be 00.
REQ-008 The block SHALL hold a 4-bit Flags register; FlagW[1]=ALUOp&Funct[0] SHALL update N and Z, and FlagW[0]=FlagW[1]&(ADD|SUB) SHALL update C and V, on the clock edge that leaves EXECR or EXECI, only when CondEx=1.
REQ-009 CondEx SHALL be combinational from Cond and the Flags register using the ARM codes 0000-1110 (EQ..AL); Cond=1111 SHALL give CondEx=0.
REQ-010 The gated outputs SHALL be:
- RegWrite = RegW & CondEx.
- MemWrite = MemW & CondEx.
- PCWrite = NextPC | (Branch & CondEx) | (RegW & CondEx & Rd==1111).
REQ-011 Writeback and branch states SHALL still be visited when CondEx=0, with their writes suppressed, so that latency is fixed.
REQ-012 Latency without memory waits SHALL be: data-processing 4 cycles, load 5 cycles, store 4 cycles, branch 3 cycles, Op=11 2 cycles.

Reset
REQ-013 While reset=0, the state SHALL be forced to FETCH, Flags to 0000, and PCWrite, IRWrite, RegWrite and MemWrite to 0; the other outputs SHALL take their FETCH values.
REQ-014 After the first rising clk edge following reset deassertion, the FSM SHALL begin in FETCH; an assertion of reset in any state SHALL take effect immediately, without waiting for a clock edge.

Configuration
REQ-015 With MC_MEM_WAIT_EN defined, FETCH, MEMREAD and MEMWRITE SHALL hold their state while MemReady=0, and IRWrite, NextPC and MemW SHALL assert only in the cycle in which MemReady=1.
REQ-016 Without MC_MEM_WAIT_EN defined, MemReady SHALL be ignored and each of those states SHALL last exactly one cycle; the port list SHALL be identical in both builds.

Verification
REQ-017 Release reset with Instr=0xE0812003 (ADD R2,R1,R3) -> FETCH, DECODE, EXECR, ALUWB; ALUControl=00 in EXECR; RegWrite=1 in ALUWB; PCWrite=1 only in FETCH.
REQ-018 Set Flags Z=1 via SUBS, then issue 0x1A000002 (BNE) -> BRANCH visited, PCWrite=0 in BRANCH; repeat with Z=0 -> PCWrite=1 in BRANCH.
REQ-019 Issue 0xE5912000 (LDR) -> MEMADR, MEMREAD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1); issue 0xE5812000 (STR) -> MemWrite=1 in MEMWRITE only.
REQ-020 Issue 0xE281F004 (ADD PC,R1,#4) -> in ALUWB, RegWrite=1 and PCWrite=1.
REQ-021 Drive reset low mid-MEMWB -> state is FETCH and RegWrite=0 immediately, without a clock edge.
REQ-022 With MC_MEM_WAIT_EN defined, hold MemReady=0 for 3 cycles in FETCH -> IRWrite=0 for those cycles, then IRWrite=1 for one cycle; without the macro, FETCH lasts one cycle.
